sifh_frame_scheduler: RTL

Sequencer for the pipelined SiFH histogram builder. It accepts timestamps from the TDC front end over a valid/ready handshake and forwards them to the histogram builder as `wrEn`/`data`. It runs the coarse pass and the optional fine pass for one frame, clears the histogram RAM before each pass, and waits for the builder pipeline to drain. It sits between the TDC interface and the histogram builder and owns all pixel, acquisition and pass counting at frame level.

---
 rtl/sifh_frame_scheduler.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/sifh_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sifh_frame_scheduler
// Purpose  : Frame-level sequencer for the pipelined SiFH histogram builder.
//            It accepts TDC timestamps over valid/ready and forwards them to
//            the builder as hb_wrEn/hb_data. For each frame it runs a coarse
//            pass and, optionally, a fine pass. Before each pass it clears the
//            histogram RAM. After each pass it waits for the builder pipeline
//            to drain.
// Option   : `SIFH_FINE_PASS_EN -- when defined, a fine pass follows the
//            coarse pass. When undefined, there is one coarse pass per frame
//            and hb_pass is tied to 0.
// Ports    : clk        - sole clock, rising edge
//            res        - synchronous active-low reset
//            start      - begin a frame (sampled in IDLE only)
//            tdc_valid  - front-end sample valid
//            tdc_data   - timestamp, all-ones = no photon (forwarded as-is)
//            tdc_ready  - sample accepted this cycle (RUN only)
//            hb_wrEn    - registered write strobe to builder
//            hb_data    - registered timestamp to builder
//            hb_res     - active-low histogram clear (low in CLEAR)
//            hb_pass    - 0 = coarse pass, 1 = fine pass
//            pixel_idx  - pixel of the transfer on hb_data
//            busy       - high in every state except IDLE
//            frame_done - one-cycle pulse at frame end
//            frame_cnt  - completed frames, wraps 255 -> 0
// Revision : 1.0 - initial release
// ============================================================================
module sifh_frame_scheduler #(
  parameter int NP        = 8,
  parameter int PIXEL_NUM = 200,
  parameter int DATA_NUM  = 2,
  parameter int ACQ_NUM   = 33333,
  parameter int CLR_CYC   = 2,
  parameter int DRAIN_CYC = 4
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic                         start,
  input  logic                         tdc_valid,
  input  logic [NP-1:0]                tdc_data,
  output logic                         tdc_ready,
  output logic                         hb_wrEn,
  output logic [NP-1:0]                hb_data,
  output logic                         hb_res,
  output logic                         hb_pass,
  output logic [$clog2(PIXEL_NUM)-1:0] pixel_idx,
  output logic                         busy,
  output logic                         frame_done,
  output logic [7:0]                   frame_cnt
);

  localparam int PW   = $clog2(PIXEL_NUM);
  localparam int DW   = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
  localparam int AW   = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
  localparam int TMAX = (CLR_CYC > DRAIN_CYC) ? CLR_CYC : DRAIN_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [DW-1:0] DATA_LAST  = DW'(DATA_NUM - 1);
  localparam logic [PW-1:0] PIX_LAST   = PW'(PIXEL_NUM - 1);
  localparam logic [AW-1:0] ACQ_LAST   = AW'(ACQ_NUM - 1);
  localparam logic [TW-1:0] CLR_LAST   = TW'(CLR_CYC - 1);
  localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_CYC - 1);

`ifdef SIFH_FINE_PASS_EN
  localparam bit FINE_EN = 1'b1;
`else
  localparam bit FINE_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q;
  logic [DW-1:0]   in_cnt_q;
  logic [PW-1:0]   pix_cnt_q;
  logic [AW-1:0]   acq_cnt_q;
  logic            wren_q;
  logic [NP-1:0]   data_q;
  logic [PW-1:0]   pix_idx_q;
  logic            done_q;
  logic [7:0]      frame_cnt_q;
  logic            pass_q;

  // Transfer qualified from state directly, so next-state logic does not
  // loop back through tdc_ready.
  logic xfer, last_xfer;
  assign xfer      = tdc_valid && (state_q == S_RUN);
  assign last_xfer = xfer && (in_cnt_q == DATA_LAST) &&
                     (pix_cnt_q == PIX_LAST) && (acq_cnt_q == ACQ_LAST);

  always_comb begin
    state_d   = state_q;
    tdc_ready = 1'b0;
    hb_res    = 1'b1;
    busy      = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        hb_res = 1'b0;
        if (timer_q == CLR_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        tdc_ready = 1'b1;
        if (last_xfer) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (timer_q == DRAIN_LAST) begin
          if (FINE_EN && !pass_q) state_d = S_CLEAR;
          else                    state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      in_cnt_q    <= '0;
      pix_cnt_q   <= '0;
      acq_cnt_q   <= '0;
      wren_q      <= 1'b0;
      data_q      <= '0;
      pix_idx_q   <= '0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;

      // One timer serves both CLEAR and DRAIN; it restarts on every state change.
      if (state_d != state_q) timer_q <= '0;
      else if (state_q == S_CLEAR || state_q == S_DRAIN) timer_q <= timer_q + TW'(1);

      if (state_q == S_CLEAR) begin
        in_cnt_q  <= '0;
        pix_cnt_q <= '0;
        acq_cnt_q <= '0;
      end else if (xfer) begin
        if (in_cnt_q == DATA_LAST) begin
          in_cnt_q <= '0;
          if (pix_cnt_q == PIX_LAST) begin
            pix_cnt_q <= '0;
            acq_cnt_q <= (acq_cnt_q == ACQ_LAST) ? '0 : acq_cnt_q + AW'(1);
          end else begin
            pix_cnt_q <= pix_cnt_q + PW'(1);
          end
        end else begin
          in_cnt_q <= in_cnt_q + DW'(1);
        end
      end

      wren_q <= xfer;
      if (xfer) begin
        data_q    <= tdc_data;
        pix_idx_q <= pix_cnt_q;
      end

      // Pulse lands the cycle after DONE, together with the count update.
      done_q <= (state_q == S_DONE);
      if (state_q == S_DONE) frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

`ifdef SIFH_FINE_PASS_EN
  // Moves only on DRAIN->CLEAR (to fine) or IDLE->CLEAR (back to coarse).
  always_ff @(posedge clk) begin
    if (!res) begin
      pass_q <= 1'b0;
    end else if (state_q == S_DRAIN && state_d == S_CLEAR) begin
      pass_q <= 1'b1;
    end else if (state_q == S_IDLE && start) begin
      pass_q <= 1'b0;
    end
  end
`else
  assign pass_q = 1'b0;
`endif

  assign hb_wrEn    = wren_q;
  assign hb_data    = data_q;
  assign hb_pass    = pass_q;
  assign pixel_idx  = pix_idx_q;
  assign frame_done = done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
`default_nettype wire
